// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU opcodes, operand-2 source encodings,
// operand-stage FSM states and the register-number width.
package pipeline_pkg;

  localparam int REGW = 5;

  // ALU opcodes
  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_LUI  = 4'd7;
  localparam logic [3:0] ALU_ADD  = 4'd8;
  localparam logic [3:0] ALU_ADDU = 4'd9;
  localparam logic [3:0] ALU_SUB  = 4'd10;
  localparam logic [3:0] ALU_SUBU = 4'd11;
  localparam logic [3:0] ALU_SLL  = 4'd12;
  localparam logic [3:0] ALU_SRL  = 4'd13;
  localparam logic [3:0] ALU_SRA  = 4'd14;

  // Operand-2 source select
  localparam logic [1:0] SRC_RT    = 2'd0;
  localparam logic [1:0] SRC_IMM   = 2'd1;
  localparam logic [1:0] SRC_SHAMT = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_HAZARD = 2'd2
  } state_e;

  // rt is read by every form except the immediate form
  function automatic logic uses_rt(input logic [1:0] src_sel);
    return (src_sel != SRC_IMM);
  endfunction

endpackage

// File: rtl/operand_forward.sv
// Per-operand bypass mux: EX/MEM beats MEM/WB beats the register file.
// Register 0 always reads the register-file value.
module operand_forward #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] src_num,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exmem_we,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_data,
  input  logic            memwb_we,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic [XLEN-1:0] fwd_data
);

  // Priority select of the freshest producer of src_num
  always_comb begin
    fwd_data = rf_data;
    if (src_num == {REGW{1'b0}}) begin
      fwd_data = rf_data;
    end else if (exmem_we && (exmem_rd == src_num)) begin
      fwd_data = exmem_data;
    end else if (memwb_we && (memwb_rd == src_num)) begin
      fwd_data = memwb_data;
    end else begin
      fwd_data = rf_data;
    end
  end

endmodule

// File: rtl/exe_operand_stage.sv
// ID/EX operand stage in front of the ALU: valid/ready capture, operand
// formation with RAW bypassing, load-use stall, flush.
// Build option: define EXE_FWD_EN to enable the bypass paths; without it
// any pending-write match stalls decode and operands come from the
// register file.
module exe_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = pipeline_pkg::REGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [REGW-1:0] dec_rs_num,
  input  logic [REGW-1:0] dec_rt_num,
  input  logic [REGW-1:0] dec_rd_num,
  input  logic [XLEN-1:0] dec_rs_data,
  input  logic [XLEN-1:0] dec_rt_data,
  input  logic [15:0]     dec_imm,
  input  logic            dec_imm_signed,
  input  logic [4:0]      dec_shamt,
  input  logic [1:0]      dec_src_sel,
  input  logic [3:0]      dec_alu_operation,
  input  logic            dec_reg_write,
  input  logic            dec_is_load,
  input  logic            exmem_reg_write,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_data,
  input  logic            exmem_is_load,
  input  logic            memwb_reg_write,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_input1,
  output logic [XLEN-1:0] alu_input2,
  output logic [3:0]      alu_operation,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_is_load
);
  import pipeline_pkg::*;

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [3:0]      op_q, op_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic            rw_q, rw_d, ld_q, ld_d;

  logic            rt_used_s, load_use_s, hazard_s;
  logic            fwd_ex_we_s, fwd_wb_we_s;
  logic            ready_s, capture_s, retire_s;
  logic [XLEN-1:0] rs_fwd_s, rt_fwd_s, op1_s, op2_s;

  // Load-use detection, plus plain RAW stalls when bypassing is absent
  always_comb begin
    rt_used_s  = uses_rt(dec_src_sel);
    load_use_s = exmem_reg_write && exmem_is_load && (exmem_rd != {REGW{1'b0}}) &&
                 ((exmem_rd == dec_rs_num) || (rt_used_s && (exmem_rd == dec_rt_num)));
`ifdef EXE_FWD_EN
    hazard_s    = load_use_s;
    fwd_ex_we_s = exmem_reg_write;
    fwd_wb_we_s = memwb_reg_write;
`else
    // A load match is a subset of the EX/MEM match, so load_use_s adds nothing new
    hazard_s = load_use_s ||
               (exmem_reg_write && (exmem_rd != {REGW{1'b0}}) &&
                ((exmem_rd == dec_rs_num) || (exmem_rd == dec_rt_num))) ||
               (memwb_reg_write && (memwb_rd != {REGW{1'b0}}) &&
                ((memwb_rd == dec_rs_num) || (memwb_rd == dec_rt_num)));
    fwd_ex_we_s = 1'b0;
    fwd_wb_we_s = 1'b0;
`endif
  end

  operand_forward #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs (
    .src_num    (dec_rs_num),
    .rf_data    (dec_rs_data),
    .exmem_we   (fwd_ex_we_s),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_data),
    .memwb_we   (fwd_wb_we_s),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_data),
    .fwd_data   (rs_fwd_s)
  );

  operand_forward #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rt (
    .src_num    (dec_rt_num),
    .rf_data    (dec_rt_data),
    .exmem_we   (fwd_ex_we_s),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_data),
    .memwb_we   (fwd_wb_we_s),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_data),
    .fwd_data   (rt_fwd_s)
  );

  // Operand formation from the selected sources
  always_comb begin
    case (dec_src_sel)
      SRC_IMM: begin
        op1_s = rs_fwd_s;
        op2_s = dec_imm_signed ? {{(XLEN-16){dec_imm[15]}}, dec_imm}
                               : {{(XLEN-16){1'b0}}, dec_imm};
      end
      SRC_SHAMT: begin
        op1_s = rt_fwd_s;
        op2_s = {{(XLEN-5){1'b0}}, dec_shamt};
      end
      default: begin
        op1_s = rs_fwd_s;
        op2_s = rt_fwd_s;
      end
    endcase
  end

  // Handshake and next-state logic; flush dominates capture and hazards
  always_comb begin
    case (state_q)
      ST_EMPTY:  ready_s = !hazard_s;
      ST_FULL:   ready_s = ex_ready && !hazard_s;
      ST_HAZARD: ready_s = (!valid_q || ex_ready) && !hazard_s;
      default:   ready_s = 1'b0;
    endcase
    if (flush) begin
      ready_s = 1'b0;
    end else begin
      ready_s = ready_s;
    end
    capture_s = dec_valid && ready_s;
    retire_s  = valid_q && ex_ready;

    if (flush) begin
      state_d = ST_EMPTY;
    end else if (dec_valid && hazard_s) begin
      state_d = ST_HAZARD;
    end else if (capture_s || (valid_q && !ex_ready)) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_EMPTY;
    end
  end

  // Output register contents: capture, bubble on flush/retire, else hold
  always_comb begin
    valid_d = valid_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    ld_d    = ld_q;
    if (flush || (retire_s && !capture_s)) begin
      valid_d = 1'b0;
      in1_d   = {XLEN{1'b0}};
      in2_d   = {XLEN{1'b0}};
      op_d    = ALU_NOP;
      rd_d    = {REGW{1'b0}};
      rw_d    = 1'b0;
      ld_d    = 1'b0;
    end else if (capture_s) begin
      valid_d = 1'b1;
      in1_d   = op1_s;
      in2_d   = op2_s;
      op_d    = dec_alu_operation;
      rd_d    = dec_rd_num;
      rw_d    = dec_reg_write;
      ld_d    = dec_is_load;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      in1_q   <= {XLEN{1'b0}};
      in2_q   <= {XLEN{1'b0}};
      op_q    <= ALU_NOP;
      rd_q    <= {REGW{1'b0}};
      rw_q    <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      ld_q    <= ld_d;
    end
  end

  assign dec_ready     = ready_s;
  assign ex_valid      = valid_q;
  assign alu_input1    = in1_q;
  assign alu_input2    = in2_q;
  assign alu_operation = op_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = rw_q;
  assign ex_is_load    = ld_q;

endmodule

// File: doc/exe_operand_stage.md
Name: exe_operand_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU.
- Captures decoded instructions using a valid/ready handshake.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and stalls decode on load-use.
- Presents registered input1/input2/alu_operation to the ALU, plus the destination tag for writeback.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register-number width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- dec_valid  in  1  decode offers an instruction
- dec_ready  out  1  stage accepts this cycle
- dec_rs_num  in  REGW  source register 1
- dec_rt_num  in  REGW  source register 2
- dec_rd_num  in  REGW  destination register
- dec_rs_data  in  XLEN  register-file value of rs
- dec_rt_data  in  XLEN  register-file value of rt
- dec_imm  in  16  immediate
- dec_imm_signed  in  1  1 = sign-extend imm, 0 = zero-extend
- dec_shamt  in  5  shift amount
- dec_src_sel  in  2  operand-2 source: 0 = rt, 1 = imm, 2 = shamt (input1 becomes rt)
- dec_alu_operation  in  4  ALU opcode, passed through
- dec_reg_write  in  1  instruction writes rd
- dec_is_load  in  1  instruction is a load
- exmem_reg_write  in  1  EX/MEM holds a writing instruction
- exmem_rd  in  REGW  EX/MEM destination register
- exmem_data  in  XLEN  EX/MEM result
- exmem_is_load  in  1  EX/MEM instruction is a load (data not yet available)
- memwb_reg_write  in  1  MEM/WB writes
- memwb_rd  in  REGW  MEM/WB destination register
- memwb_data  in  XLEN  MEM/WB result
- flush  in  1  kill the held instruction (branch mispredict)
- ex_ready  in  1  ALU/EX stage accepts
- ex_valid  out  1  outputs hold a valid instruction
- alu_input1  out  XLEN  ALU operand 1
- alu_input2  out  XLEN  ALU operand 2
- alu_operation  out  4  ALU opcode
- ex_rd  out  REGW  destination register
- ex_reg_write  out  1  destination write enable
- ex_is_load  out  1  load flag

Behaviour:
- Reset (rst=1 at a clk edge):
  - ex_valid=0, alu_input1=0, alu_input2=0, alu_operation=0 (NOP), ex_rd=0, ex_reg_write=0, ex_is_load=0.
  - FSM goes to EMPTY.
  - Reset mid-operation discards the held instruction; no partial state survives.
- FSM states: EMPTY, FULL, HAZARD.
  - EMPTY: dec_ready=1 unless a load-use hazard exists. On dec_valid & no hazard, capture and go to FULL. On dec_valid & hazard, go to HAZARD and capture nothing.
  - FULL: dec_ready = ex_ready & no hazard. The ex_valid & ex_ready handshake retires the entry. A simultaneous new capture keeps the state FULL. Otherwise the state goes to EMPTY.
  - HAZARD: dec_ready=0 for exactly one cycle. Return to EMPTY, or stay FULL if the previous entry is not yet retired. Decode must hold its inputs stable while dec_ready=0.
- Load-use hazard: exmem_reg_write & exmem_is_load & exmem_rd≠0 & (exmem_rd==dec_rs_num, or exmem_rd==dec_rt_num when operand 2 uses rt).
- Forwarding is applied at capture only. Per operand, priority is EX/MEM, then MEM/WB, then register file.
- Register 0 is never forwarded; it always reads dec_*_data.
- Operand formation:
  - src_sel 0: input1 = fwd rs, input2 = fwd rt.
  - src_sel 1: input1 = fwd rs, input2 = extended imm.
  - src_sel 2: input1 = fwd rt, input2 = {XLEN-5 zeros, shamt}.
  - src_sel 3: treated as 0.
- Latency: one cycle from capture to ex_valid.
- Outputs are stable while ex_valid & !ex_ready.
- flush: clears ex_valid and dec_ready for that cycle, and the state goes to EMPTY. Flush overrides a simultaneous capture and dominates the hazard condition.
- A bubble drives ex_reg_write=0 and alu_operation=NOP.

Optional Feature:
- Macro: EXE_FWD_EN.
- Defined: forwarding as described above.
- Undefined:
  - No bypass paths.
  - Any match of rs/rt against exmem_rd or memwb_rd with reg_write set and rd≠0 holds the FSM in HAZARD until no match remains.
  - Operands are always taken from the register file.

Decomposition:
- Shared package pipeline_pkg holds:
  - ALU opcode localparams (NOP=0 … SRA=14).
  - src_sel encodings.
  - FSM state enum.
  - REGW.
- Sub-module operand_forward: combinational per-operand priority mux over EX/MEM, MEM/WB and register file, including the zero-register check. It is instantiated twice.

Test Plan:
- Reset, then send ADD with rs=1 (data 5) and rt=2 (data 7), no forwarding → next cycle: ex_valid=1, input1=5, input2=7, alu_operation=8.
- EX/MEM rd=3 data 0x10 and MEM/WB rd=3 data 0x20 both writing; instruction uses rs=3 → input1=0x10 (EX/MEM priority).
- EX/MEM is a load to rd=4; incoming instruction uses rt=4 → dec_ready=0 for one cycle. Next cycle, with MEM/WB rd=4 data 0x55, the instruction is captured with input2=0x55.
- src_sel=1, imm=0xFFFF, signed=1 → input2=0xFFFFFFFF. With signed=0 → input2=0x0000FFFF.
- ex_ready=0 for 3 cycles with a new dec_valid → outputs held and dec_ready=0. Then ex_ready=1 → retire and capture occur in the same cycle.
- flush asserted together with dec_valid while FULL → ex_valid=0 next cycle and the new instruction is not captured.
